// File: rtl/fpu_add_seq_pkg.sv
// Shared types and constants for the FPU add/sub sequencer.
package fpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CMP,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_DONE
  } state_e;

  localparam logic [1:0] A_GREATER = 2'b10;
  localparam logic [1:0] A_LESS    = 2'b00;
  localparam logic [1:0] A_EQUAL   = 2'b11;

  typedef enum logic [1:0] {
    RC_NORMAL = 2'b00,
    RC_ZERO   = 2'b01,
    RC_DENORM = 2'b10,
    RC_LIMIT  = 2'b11
  } result_class_e;

  localparam int unsigned MAX_SHIFT = 31;
  localparam int unsigned SHIFT_W   = $clog2(MAX_SHIFT + 1);

endpackage

// File: rtl/fpu_add_seq_if.sv
// Operand-accept and result-present handshakes of the add/sub sequencer.
interface fpu_add_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] result_class;

  modport master (
    output in_valid, out_ready,
    input  in_ready, out_valid, result_class
  );

  modport slave (
    input  in_valid, out_ready,
    output in_ready, out_valid, result_class
  );
endinterface

// File: rtl/fpu_add_seq_align_cnt.sv
// Remaining-alignment counter: hands out at most ALIGN_STEP bits of right shift per step.
module fpu_align_cnt
  import fpu_pkg::*;
#(
  parameter int unsigned ALIGN_STEP = 4,
  localparam int unsigned AMT_W     = $clog2(ALIGN_STEP + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [SHIFT_W-1:0] shift_i,
  input  logic               step_i,
  output logic [AMT_W-1:0]   amt_o,
  output logic               last_o
);

  localparam logic [SHIFT_W-1:0] STEP_S = SHIFT_W'(ALIGN_STEP);
  localparam logic [AMT_W-1:0]   STEP_A = AMT_W'(ALIGN_STEP);

  logic [SHIFT_W-1:0] rem_q, rem_d;

  always_comb begin
    amt_o  = (rem_q > STEP_S) ? STEP_A : rem_q[AMT_W-1:0];
    last_o = (rem_q <= STEP_S);
    rem_d  = rem_q;
    if (load_i) begin
      rem_d = shift_i;
    end else if (step_i) begin
      rem_d = rem_q - SHIFT_W'(amt_o);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
    end else begin
      rem_q <= rem_d;
    end
  end

endmodule

// File: rtl/fpu_add_seq.sv
// Control sequencer for the FPU add/sub datapath: load, compare, align, add, normalize, present.
module fpu_add_seq
  import fpu_pkg::*;
#(
  parameter int unsigned MAN_WIDTH  = 23,
  parameter int unsigned ALIGN_STEP = 4,
  parameter int unsigned NORM_LIMIT = MAN_WIDTH + 3,
  localparam int unsigned AMT_W     = $clog2(ALIGN_STEP + 1)
) (
  input  logic               clk,
  input  logic               rst,
  fpu_add_seq_if.slave       bus,
  output logic               ld_op,
  input  logic [1:0]         exp_disc,
  input  logic [SHIFT_W-1:0] shift_spaces,
  output logic               swap,
  output logic               align_en,
  output logic [AMT_W-1:0]   align_amt,
  output logic               add_en,
  input  logic               man_zero,
  input  logic               man_ovf,
  input  logic               man_msb,
  input  logic               exp_at_min,
  output logic               norm_right,
  output logic               norm_left,
  output logic               busy
);

  localparam int unsigned CNT_W = $clog2(NORM_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(NORM_LIMIT);

  state_e            state_q, state_d;
  logic              swap_q, swap_d;
  logic [CNT_W-1:0]  norm_cnt_q, norm_cnt_d;
  result_class_e     class_q, class_d;

  logic              load_rem;
  logic              align_s, add_s, nright_s, nleft_s;
  logic [AMT_W-1:0]  step_amt;
  logic              step_last;

  fpu_align_cnt #(.ALIGN_STEP(ALIGN_STEP)) u_align (
    .clk    (clk),
    .rst    (rst),
    .load_i (load_rem),
    .shift_i(shift_spaces),
    .step_i (align_s),
    .amt_o  (step_amt),
    .last_o (step_last)
  );

  always_comb begin
    state_d    = state_q;
    swap_d     = swap_q;
    norm_cnt_d = norm_cnt_q;
    class_d    = class_q;
    load_rem   = 1'b0;
    align_s    = 1'b0;
    add_s      = 1'b0;
    nright_s   = 1'b0;
    nleft_s    = 1'b0;
    unique case (state_q)
      S_IDLE:  if (bus.in_valid) state_d = S_LOAD;
      S_LOAD:  state_d = S_CMP;
      S_CMP: begin
        load_rem = 1'b1;
        // 01 is not a legal compare result; it resolves like "equal" (no swap).
        case (exp_disc)
          A_LESS:              swap_d = 1'b1;
          A_GREATER, A_EQUAL:  swap_d = 1'b0;
          default:             swap_d = 1'b0;
        endcase
        state_d = (shift_spaces != '0) ? S_ALIGN : S_ADD;
      end
      S_ALIGN: begin
        align_s = 1'b1;
        if (step_last) state_d = S_ADD;
      end
      S_ADD: begin
        add_s      = 1'b1;
        norm_cnt_d = '0;
        state_d    = S_NORM;
      end
      S_NORM: begin
        // Carry-out right shifts do not consume the left-normalize budget.
        if (man_zero) begin
          class_d = RC_ZERO;
          state_d = S_DONE;
        end else if (man_ovf) begin
          nright_s = 1'b1;
        end else if (man_msb) begin
          class_d = RC_NORMAL;
          state_d = S_DONE;
        end else if (exp_at_min) begin
          class_d = RC_DENORM;
          state_d = S_DONE;
        end else if (norm_cnt_q == CNT_LIMIT) begin
          class_d = RC_LIMIT;
          state_d = S_DONE;
        end else begin
          nleft_s    = 1'b1;
          norm_cnt_d = norm_cnt_q + 1'b1;
        end
      end
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      swap_q     <= 1'b0;
      norm_cnt_q <= '0;
      class_q    <= RC_NORMAL;
    end else begin
      state_q    <= state_d;
      swap_q     <= swap_d;
      norm_cnt_q <= norm_cnt_d;
      class_q    <= class_d;
    end
  end

  // Outputs are forced low while reset is held, before the state register clears.
  always_comb begin
    bus.in_ready     = (state_q == S_IDLE) && !rst;
    ld_op            = bus.in_valid && bus.in_ready;
    swap             = swap_q && !rst;
    align_en         = align_s && !rst;
    align_amt        = align_en ? step_amt : '0;
    add_en           = add_s && !rst;
    norm_right       = nright_s && !rst;
    norm_left        = nleft_s && !rst;
    bus.out_valid    = (state_q == S_DONE) && !rst;
    bus.result_class = rst ? 2'b00 : class_q;
    busy             = (state_q != S_IDLE) && !rst;
  end

endmodule
